// File: rtl/bcd_store_unit.sv
// rtl/bcd_store_unit.sv - multi-cycle double-dabble binary-to-BCD converter with optional digit store
module bcd_store_unit #(
  parameter int WIDTH      = 8,
  parameter int DIGITS     = 3,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      value_i,
  input  logic                  store_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [7:0]            wr_data_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(DIGITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [BW-1:0]         acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  store_q, store_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         digits_q, digits_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;

  logic [BW-1:0]         acc_adj;
  logic [BW+WIDTH-1:0]   sh_full;
  logic [BW-1:0]         acc_sh;
  logic [WIDTH-1:0]      bin_sh;
  logic [IW-1:0]         idx_nxt;

  function automatic logic [3:0] nibble(input logic [BW-1:0] v, input logic [IW-1:0] sel);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == IW'(i)) r = v[4*i +: 4];
    end
    return r;
  endfunction

  // Add-3 correction is applied before the shift so each digit stays valid BCD after doubling.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  assign sh_full = {acc_adj, bin_q} << 1;
  assign acc_sh  = sh_full[BW+WIDTH-1:WIDTH];
  assign bin_sh  = sh_full[WIDTH-1:0];
  assign idx_nxt = idx_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    store_d   = store_q;
    base_d    = base_q;
    idx_d     = idx_q;
    digits_d  = digits_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          bin_d   = value_i;
          store_d = store_i;
          base_d  = base_addr_i;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = acc_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          digits_d = acc_sh;
          if (store_q) begin
            state_d   = S_STORE;
            idx_d     = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = {4'h0, acc_sh[BW-1 -: 4]};
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_STORE: begin
        idx_d = idx_nxt;
        // Address arithmetic is modulo the address width, so a store may wrap past the top.
        if (idx_nxt < IW'(DIGITS)) begin
          wr_addr_d = base_q + ADDR_WIDTH'(idx_nxt);
          wr_data_d = {4'h0, nibble(digits_q, IW'(DIGITS - 1) - idx_nxt)};
        end else begin
          state_d = S_IDLE;
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      store_q   <= 1'b0;
      base_q    <= '0;
      idx_q     <= '0;
      digits_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      store_q   <= store_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      digits_q  <= digits_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign digits_o  = digits_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_bcd_store_unit.sv
// tb/tb_bcd_store_unit.sv - directed table-driven bench for bcd_store_unit (8-bit and 16-bit instances)
module tb_bcd_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, store;
  logic [7:0]  value;
  logic [11:0] base;
  logic        busy, done, wr_en;
  logic [11:0] digits, wr_addr;
  logic [7:0]  wr_data;

  logic        w_start, w_store;
  logic [15:0] w_value;
  logic [11:0] w_base;
  logic        w_busy, w_done, w_wr_en;
  logic [19:0] w_digits;
  logic [11:0] w_wr_addr;
  logic [7:0]  w_wr_data;

  bcd_store_unit #(.WIDTH(8), .DIGITS(3), .ADDR_WIDTH(12)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .value_i(value), .store_i(store),
    .base_addr_i(base), .busy_o(busy), .done_o(done), .digits_o(digits),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  bcd_store_unit #(.WIDTH(16), .DIGITS(5), .ADDR_WIDTH(12)) u_wide (
    .clk_i(clk), .rst_ni(rst_n), .start_i(w_start), .value_i(w_value), .store_i(w_store),
    .base_addr_i(w_base), .busy_o(w_busy), .done_o(w_done), .digits_o(w_digits),
    .wr_en_o(w_wr_en), .wr_addr_o(w_wr_addr), .wr_data_o(w_wr_data)
  );

  logic [7:0] mem [0:4095];
  int total_writes = 0;
  int w_wr_seen = 0;
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
      total_writes <= total_writes + 1;
    end
    if (w_wr_en) w_wr_seen <= w_wr_seen + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no done within cycle budget", name);
  endtask

  typedef struct {
    logic [7:0]  v;
    logic        s;
    logic [11:0] b;
    logic [11:0] exp_dig;
  } vec_t;

  vec_t tbl[8];
  logic [11:0] cap_addr[8];
  logic [7:0]  cap_data[8];
  int          cap_m[8];

  // Issues one operation on the 8-bit instance; m counts edges after the accepting edge.
  task automatic run_narrow(input logic [7:0] v, input logic s, input logic [11:0] b,
                            output int lat, output int busy_cnt, output int nwr);
    @(negedge clk);
    start = 1'b1; value = v; store = s; base = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1; busy_cnt = 0; nwr = 0;
    for (int m = 0; m < 40; m++) begin
      if (busy) busy_cnt++;
      if (wr_en) begin
        if (nwr < 8) begin
          cap_addr[nwr] = wr_addr;
          cap_data[nwr] = wr_data;
          cap_m[nwr]    = m;
        end
        nwr++;
      end
      if (done) begin
        lat = m;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) timeout("narrow_op");
    else begin
      @(negedge clk);
      check("done_width", {31'b0, done}, 32'd0);
      check("busy_after_done", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic wait_done(input int from_m, output int at_m);
    at_m = -1;
    for (int m = from_m; m < from_m + 40; m++) begin
      if (done) begin
        at_m = m;
        break;
      end
      @(negedge clk);
    end
    if (at_m < 0) timeout("wait_done");
  endtask

  task automatic run_wide(input logic [15:0] v, input logic [19:0] exp);
    int lat;
    @(negedge clk);
    w_start = 1'b1; w_value = v; w_store = 1'b0; w_base = 12'h000;
    @(posedge clk);
    @(negedge clk);
    w_start = 1'b0;
    lat = -1;
    for (int m = 0; m < 40; m++) begin
      if (w_done) begin
        lat = m;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) timeout("wide_op");
    else begin
      check($sformatf("wide_lat_%0d", v), lat, 32'd16);
      check($sformatf("wide_digits_%0d", v), {12'b0, w_digits}, {12'b0, exp});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, nwr, lat2, tw0;
    logic [11:0] ed, ea;
    logic [7:0]  edat;

    tbl[0] = '{8'd42,  1'b0, 12'h000, 12'h042};
    tbl[1] = '{8'd255, 1'b1, 12'h020, 12'h255};
    tbl[2] = '{8'd7,   1'b1, 12'hFFF, 12'h007};
    tbl[3] = '{8'd0,   1'b0, 12'h000, 12'h000};
    tbl[4] = '{8'd100, 1'b1, 12'h100, 12'h100};
    tbl[5] = '{8'd99,  1'b0, 12'h000, 12'h099};
    tbl[6] = '{8'd9,   1'b0, 12'h000, 12'h009};
    tbl[7] = '{8'd128, 1'b1, 12'h7FE, 12'h128};

    rst_n = 1'b0;
    start = 1'b0; value = '0; store = 1'b0; base = '0;
    w_start = 1'b0; w_value = '0; w_store = 1'b0; w_base = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_digits", {20'b0, digits}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_wr_addr", {20'b0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'b0, wr_data}, 32'd0);
    check("rst_w_digits", {12'b0, w_digits}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_narrow(tbl[i].v, tbl[i].s, tbl[i].b, lat, bc, nwr);
      ed = tbl[i].exp_dig;
      check($sformatf("v%0d_latency", i), lat, tbl[i].s ? 32'd11 : 32'd8);
      check($sformatf("v%0d_busy_cycles", i), bc, tbl[i].s ? 32'd11 : 32'd8);
      check($sformatf("v%0d_digits", i), {20'b0, digits}, {20'b0, ed});
      check($sformatf("v%0d_nwrites", i), nwr, tbl[i].s ? 32'd3 : 32'd0);
      for (int k = 0; k < 3; k++) begin
        if (k < nwr) begin
          ea   = tbl[i].b + 12'(k);
          edat = {4'h0, ed[4*(2-k) +: 4]};
          check($sformatf("v%0d_wr%0d_addr", i, k), {20'b0, cap_addr[k]}, {20'b0, ea});
          check($sformatf("v%0d_wr%0d_data", i, k), {24'b0, cap_data[k]}, {24'b0, edat});
          check($sformatf("v%0d_wr%0d_cycle", i, k), cap_m[k], 32'(8 + k));
        end
      end
    end

    check("mem_020", {24'b0, mem[12'h020]}, 32'h02);
    check("mem_021", {24'b0, mem[12'h021]}, 32'h05);
    check("mem_022", {24'b0, mem[12'h022]}, 32'h05);
    check("mem_fff", {24'b0, mem[12'hFFF]}, 32'h00);
    check("mem_001", {24'b0, mem[12'h001]}, 32'h07);

    run_wide(16'd65535, 20'h65535);
    run_wide(16'd0,     20'h00000);
    run_wide(16'd12345, 20'h12345);
    run_wide(16'd9999,  20'h09999);
    check("wide_no_writes", w_wr_seen, 32'd0);

    // start pulsed mid-conversion with another operand must be ignored
    @(negedge clk);
    start = 1'b1; value = 8'd42; store = 1'b0; base = '0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; value = 8'd200;
    @(negedge clk);
    start = 1'b0; value = 8'd0;
    wait_done(4, lat);
    check("ignore_lat", lat, 32'd8);
    check("ignore_digits", {20'b0, digits}, 32'h042);
    @(negedge clk);
    check("ignore_no_restart", {31'b0, busy}, 32'd0);

    // start held through done: second operation accepted on the done cycle
    @(negedge clk);
    start = 1'b1; value = 8'd42; store = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wait_done(0, lat);
    check("b2b_lat1", lat, 32'd8);
    check("b2b_digits1", {20'b0, digits}, 32'h042);
    value = 8'd77;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_width", {31'b0, done}, 32'd0);
    check("b2b_busy_again", {31'b0, busy}, 32'd1);
    wait_done(lat + 1, lat2);
    check("b2b_lat2", lat2, 32'd17);
    check("b2b_digits2", {20'b0, digits}, 32'h077);
    @(negedge clk);

    // reset asserted while write k=1 is presented
    tw0 = total_writes;
    @(negedge clk);
    start = 1'b1; value = 8'd255; store = 1'b1; base = 12'h300;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("rm_wr1_en", {31'b0, wr_en}, 32'd1);
    check("rm_wr1_addr", {20'b0, wr_addr}, 32'h301);
    check("rm_wr1_data", {24'b0, wr_data}, 32'h05);
    #2 rst_n = 1'b0;
    #1;
    check("rm_busy", {31'b0, busy}, 32'd0);
    check("rm_done", {31'b0, done}, 32'd0);
    check("rm_digits", {20'b0, digits}, 32'd0);
    check("rm_wr_en", {31'b0, wr_en}, 32'd0);
    check("rm_wr_addr", {20'b0, wr_addr}, 32'd0);
    check("rm_wr_data", {24'b0, wr_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rm_quiet_%0d", c), {30'b0, wr_en, busy}, 32'd0);
    end
    check("rm_write_count", total_writes - tw0, 32'd1);
    check("rm_mem_300", {24'b0, mem[12'h300]}, 32'h02);
    run_narrow(8'd42, 1'b0, 12'h000, lat, bc, nwr);
    check("rm_after_lat", lat, 32'd8);
    check("rm_after_digits", {20'b0, digits}, 32'h042);
    check("rm_after_nwr", nwr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_store_unit.md
# bcd_store_unit

Multi-cycle, parametrised binary-to-BCD converter for the CHIP-8 core's FX33 instruction. It is generalised to any input width and digit count. It converts a binary value using shift-and-add-3 (double dabble), one bit per clock. Optionally, it then streams the digits, most significant first, into main memory at a base address. The CPU starts it and stalls on `busy`. Memory sees it as one more single-port write master.

## Interface
- `WIDTH`, default 8: binary input width.
- `DIGITS`, default 3: BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1.
- `ADDR_WIDTH`, default 12: memory address width.

Ports:
- `clk`  in  1  system clock. Everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only in IDLE.
- `value`  in  WIDTH  binary operand. Captured on the accepting edge.
- `store`  in  1  when 1, run the memory-write phase after conversion. Captured with `value`.
- `base_addr`  in  ADDR_WIDTH  address of the most significant digit. Captured with `value`.
- `busy`  out  1  high from the accepting edge until the operation completes.
- `done`  out  1  one-cycle completion pulse.
- `digits`  out  4·DIGITS  result, packed with the most significant digit in the top nibble. Updated only at completion.
- `wr_en`  out  1  memory write strobe.
- `wr_addr`  out  ADDR_WIDTH  write address.
- `wr_data`  out  8  write data: {4'h0, digit}.

## Operation
- States: IDLE, SHIFT, STORE.
- Reset: state IDLE, and all outputs are zero (`busy`, `done`, `digits`, `wr_en`, `wr_addr`, `wr_data`).
- Reset mid-operation aborts immediately, including a partially completed write phase. No further writes are issued.
- **IDLE:**
  - On `start`=1, latch `value`, `store` and `base_addr`.
  - Clear the internal BCD accumulator and load bit counter = WIDTH.
  - Go to SHIFT with `busy`←1.
  - `start` in any other state is ignored.
- **SHIFT (one edge per bit):**
  - For every accumulator digit ≥ 5, add 3.
  - Then shift {accumulator, binary} left by 1. The binary MSB enters accumulator bit 0.
  - Decrement the counter.
  - On the edge that performs the WIDTH-th shift:
    - `digits` ← final accumulator.
    - If `store`=0: go to IDLE, `busy`←0, `done`←1.
    - If `store`=1: go to STORE, digit index k=0, `wr_en`←1, `wr_addr`←base, `wr_data`←digit DIGITS−1.
- **STORE:**
  - Each edge advances k.
  - While k < DIGITS: `wr_en`=1, `wr_addr`=base+k (mod 2^ADDR_WIDTH, so it wraps 0xFFF→0x000), `wr_data`=digit DIGITS−1−k.
  - After the last write: go to IDLE, `wr_en`←0, `busy`←0, `done`←1.
- Leading zero digits are written; they are not suppressed.
- `done` is high exactly one cycle.
- `start` is accepted in the same cycle that `done` is high (back-to-back). `done` still falls after one cycle.
- `digits` holds its value until the next completion.
- The arithmetic width is fixed: accumulator 4·DIGITS bits, shift register WIDTH bits. There is no overflow, given the parameter constraint.

## Timing
- Edge E0 accepts `start`. `busy` is visible after E0.
- Shifts occur at E1…E_WIDTH.
- With `store`=0:
  - `done` and `digits` are visible after E_WIDTH, giving a latency of WIDTH cycles.
  - `busy` is low after E_WIDTH.
- With `store`=1:
  - Write k is presented after E_(WIDTH+k), for k = 0…DIGITS−1, in consecutive cycles with no gaps.
  - `done` is visible after E_(WIDTH+DIGITS), with `wr_en` low.
  - Total latency is WIDTH+DIGITS cycles.
- Memory is assumed to accept one write per cycle. There is no backpressure.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Basic conversion:** WIDTH=8, `value`=42, `store`=0 → `busy` for 8 cycles; `done` pulse 8 cycles after the accepting edge; `digits`=12'h042; `wr_en` never asserted.
- **FX33 store:** `value`=255, `store`=1, `base_addr`=0x020 → writes (0x020,2), (0x021,5), (0x022,5) in three consecutive cycles; `done` at cycle 11; memory at 0x020 reads 0x02 afterwards.
- **Address wrap:** `value`=7, `store`=1, `base_addr`=0xFFF → writes (0xFFF,0), (0x000,0), (0x001,7).
- **Wide instance:** WIDTH=16, DIGITS=5, `value`=65535 → `digits`=20'h65535 after 16 cycles; `value`=0 → `digits`=0.
- **Handshake:**
  - `start` pulsed during SHIFT with a different value → ignored; first result unchanged.
  - `start` held high through `done` → second conversion accepted on the `done` cycle.
  - `done` width is exactly 1 cycle.
- **Reset mid-op:** assert `rst_n`=0 during write k=1 → all outputs 0 asynchronously; no further `wr_en`; next `start` (`value`=42) completes normally.
